// File: rtl/pi_uart_rx.sv
// 8N1 UART receiver for the Raspberry Pi GPIO link: mid-bit sampling with a
// 2-flop synchronizer, one-cycle valid / frame_err pulses and a busy flag.
module pi_uart_rx #(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state_q;
  logic          rx_m_q;
  logic          rx_s_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          busy_q;
  logic          half_tick;
  logic          full_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
    end
  end

  always_comb begin
    half_tick = (timer_q == HALF_M1);
    full_tick = (timer_q == FULL_M1);
  end

  // The stop bit is judged at its midpoint and IDLE is re-entered right there,
  // so a start edge directly following the stop bit is still caught.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            timer_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (half_tick) begin
            timer_q <= '0;
            idx_q   <= '0;
            if (rx_s_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DATA: begin
          if (full_tick) begin
            timer_q         <= '0;
            shift_q[idx_q]  <= rx_s_q;
            idx_q           <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        STOP: begin
          if (full_tick) begin
            timer_q <= '0;
            if (rx_s_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rx_s_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule
